// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_pkg
//  Description : Shared constants for the round-robin mux arbiter: source
//                count, select width and the 2-bit FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_SETTLE = 2'd1;
    localparam logic [STATE_W-1:0] ST_HOLD   = 2'd2;

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Combinational round-robin pick. Returns the first requesting
//                source found when searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  Ports       : req    [3:0] in  - per-source request
//                ptr    [1:0] in  - highest-priority source this round
//                winner [1:0] out - selected source (0 when any=0)
//                any          out - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    logic [SEL_W-1:0] w_idx;

    // Walk the offsets from farthest to nearest so the nearest requester
    // (lowest offset from ptr) is the last one written and therefore wins.
    // The 2-bit add wraps naturally, giving the mod-4 rotation.
    always_comb begin
        winner = '0;
        w_idx  = '0;
        any    = |req;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            w_idx = ptr + SEL_W'(i);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arbiter
//  Description : Round-robin control stage for a 4:1 mux. Grants one of four
//                requesters, lets the mux settle for a cycle, captures its
//                output and presents it downstream over valid/ready, pulsing
//                ack for the served source.
//  Ports       : clk, rst_n (async, active-low)
//                req      [3:0]   in  - per-source request
//                mux_out  [N-1:0] in  - output of the driven mux
//                sel      [1:0]   out - mux select (registered)
//                ack      [3:0]   out - one-cycle one-hot capture pulse
//                out_data [N-1:0] out - captured word (registered)
//                out_valid        out - out_data valid
//                out_ready        in  - downstream accepts out_data
//                busy             out - FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [N-1:0]       mux_out,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] ack,
    output logic [N-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    logic [STATE_W-1:0] r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_winner;
    logic               w_any;

    rr_priority_pick u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            sel       <= '0;
            ack       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    ack <= '0;
                    if (w_any) begin
                        sel     <= w_winner;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // sel has been stable for a full cycle, so mux_out is
                    // the granted source's word.
                    out_data  <= mux_out;
                    out_valid <= 1'b1;
                    ack       <= NUM_SRC'(1) << sel;
                    r_ptr     <= sel + SEL_W'(1);
                    r_state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    ack <= '0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    ack       <= '0;
                    out_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule : mux_rr_arbiter
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mux_rr_arbiter
//  Description : Self-checking bench. Three arbiters (N=4, 8, 16) share the
//                same request/ready stimulus; each drives its own 4:1 mux
//                model. A transaction-level reference model predicts grants,
//                captures, acks and pointer movement.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic        out_ready;
    logic [15:0] mux_in [4];

    always #5 clk = ~clk;

    logic [1:0]  sel4, sel8, sel16;
    logic [3:0]  ack4, ack8, ack16;
    logic [3:0]  data4;
    logic [7:0]  data8;
    logic [15:0] data16;
    logic        valid4, valid8, valid16;
    logic        busy4, busy8, busy16;
    logic [3:0]  mo4;
    logic [7:0]  mo8;
    logic [15:0] mo16;

    // Behavioural 4:1 muxes, one per width
    assign mo4  = mux_in[sel4][3:0];
    assign mo8  = mux_in[sel8][7:0];
    assign mo16 = mux_in[sel16];

    mux_rr_arbiter #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .mux_out(mo4), .sel(sel4),
        .ack(ack4), .out_data(data4), .out_valid(valid4),
        .out_ready(out_ready), .busy(busy4)
    );
    mux_rr_arbiter #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .mux_out(mo8), .sel(sel8),
        .ack(ack8), .out_data(data8), .out_valid(valid8),
        .out_ready(out_ready), .busy(busy8)
    );
    mux_rr_arbiter #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .req(req), .mux_out(mo16), .sel(sel16),
        .ack(ack16), .out_data(data16), .out_valid(valid16),
        .out_ready(out_ready), .busy(busy16)
    );

    // ------------------------------------------------------------------
    // Reference model: transaction phase (0 waiting for request,
    // 1 granted / waiting to capture, 2 word held downstream)
    // ------------------------------------------------------------------
    int          m_phase, m_ptr, m_sel;
    logic [3:0]  m_ack;
    logic [15:0] m_data;
    logic        m_valid;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ack_cnt  = 0;
    logic [7:0]  cap8 [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_sel = 0;
        m_ack = '0; m_data = '0; m_valid = 1'b0;
    endtask

    task automatic model_edge();
        bit found;
        int idx;
        case (m_phase)
            0: begin
                m_ack = '0;
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (!found && req[idx]) begin
                        found = 1;
                        m_sel = idx;
                    end
                end
                if (found) m_phase = 1;
            end
            1: begin
                m_data  = mux_in[m_sel];
                m_valid = 1'b1;
                m_ack   = 4'(1 << m_sel);
                m_ptr   = (m_sel + 1) % 4;
                m_phase = 2;
            end
            default: begin
                m_ack = '0;
                if (out_ready) begin
                    m_valid = 1'b0;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("sel4",    sel4,    m_sel);
        check("sel8",    sel8,    m_sel);
        check("sel16",   sel16,   m_sel);
        check("ack4",    ack4,    m_ack);
        check("ack8",    ack8,    m_ack);
        check("ack16",   ack16,   m_ack);
        check("valid8",  valid8,  m_valid);
        check("valid4",  valid4,  m_valid);
        check("valid16", valid16, m_valid);
        check("busy8",   busy8,   (m_phase != 0));
        check("busy4",   busy4,   (m_phase != 0));
        check("busy16",  busy16,  (m_phase != 0));
        check("data4",   data4,   m_data[3:0]);
        check("data8",   data8,   m_data[7:0]);
        check("data16",  data16,  m_data);
        check("ack_onehot", ($countones(ack8) <= 1), 1);
        if (ack8 != 4'd0) cap8.push_back(data8);
        if (ack4 != 4'd0) ack_cnt++;
    endtask

    // One clock: model advances on the rising edge, DUT is compared on the
    // falling edge; callers change inputs afterwards.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    logic [7:0] rr_exp [5];

    initial begin
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) mux_in[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();                       // reset state

        // ---- round robin, all four requesting -------------------------
        mux_in[0] = 16'h1111; mux_in[1] = 16'h2222;
        mux_in[2] = 16'h3333; mux_in[3] = 16'h4444;
        req = 4'b1111; out_ready = 1'b1;
        cap8.delete();
        run(15);
        rr_exp[0] = 8'h11; rr_exp[1] = 8'h22; rr_exp[2] = 8'h33;
        rr_exp[3] = 8'h44; rr_exp[4] = 8'h11;
        check("rr_count", cap8.size(), 5);
        for (int i = 0; i < 5 && i < cap8.size(); i++)
            check($sformatf("rr_word%0d", i), cap8[i], rr_exp[i]);
        req = '0;
        run(2);

        // ---- pointer wrap: serve 3, then 0 wins over 3 -----------------
        mux_in[3] = 16'hBEEF; mux_in[0] = 16'hCAFE;
        req = 4'b1000;
        run(3);
        req = 4'b1001;
        step();
        check("wrap_sel", sel16, 2'd0);
        step();
        check("wrap_data", data16, 16'hCAFE);
        step();
        req = '0;
        run(2);

        // ---- back-pressure; early ready ignored ------------------------
        mux_in[1] = 16'hA5AA;
        req = 4'b0010; out_ready = 1'b1; ack_cnt = 0;
        run(2);                              // grant + capture
        out_ready = 1'b0;
        run(5);
        check("bp_valid", valid4, 1'b1);
        check("bp_data",  data4,  4'hA);
        check("bp_sel",   sel4,   2'd1);
        check("bp_acks",  ack_cnt, 1);
        req = '0; out_ready = 1'b1;
        step();
        check("bp_idle", busy4, 1'b0);

        // ---- skip from ptr=2 and single requester ----------------------
        mux_in[0] = 16'h0077;
        req = 4'b0001; ack_cnt = 0;
        step();
        check("skip_sel", sel8, 2'd0);
        run(11);
        check("single_acks", ack_cnt, 4);
        req = '0;
        run(3);

        // ---- asynchronous reset in the middle of HOLD -------------------
        req = 4'b0100; out_ready = 1'b0;
        run(3);
        check("pre_rst_valid", valid8, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", valid8, 1'b0);
        check("arst_sel",   sel8,   2'd0);
        check("arst_ack",   ack8,   4'd0);
        check("arst_data",  data8,  8'h00);
        check("arst_busy",  busy8,  1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0100; out_ready = 1'b1;
        step();
        check("post_rst_sel", sel8, 2'd2);
        run(2);

        // ---- randomized traffic ----------------------------------------
        for (int it = 0; it < 200; it++) begin
            req       = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < 4; s++) mux_in[s] = 16'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard ceiling so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule : tb_mux_rr_arbiter
`default_nettype wire
